// File: rtl/lib_uart.sv
// Shared UART definitions for the transmitter and the future receiver.
//   UART_TX_STATE           : transmitter frame phase
//   UART_CLK_PER_BIT_DEFAULT: clk cycles per serial bit (100 MHz / 115200)
package lib_uart;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } UART_TX_STATE;

    localparam int unsigned UART_CLK_PER_BIT_DEFAULT = 868;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLK_PER_BIT-1 while enabled, pulses o_tick on the last count.
//   clk     : system clock
//   reset   : synchronous, active-high reset
//   i_clear : restart the bit period at 0
//   i_en    : count enable; the counter is held at 0 when low
//   o_tick  : high in the final cycle of each bit period
module uart_baud_cnt
    import lib_uart::*;
#(
    parameter int unsigned CLK_PER_BIT = UART_CLK_PER_BIT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_en,
    output logic o_tick
);

    localparam int unsigned CNT_W = (CLK_PER_BIT < 2) ? 1 : $clog2(CLK_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_BIT - 1);

    generate
        if (CLK_PER_BIT < 2) begin : g_bad_param
            $error("uart_baud_cnt: CLK_PER_BIT must be at least 2");
        end
    endgenerate

    logic [CNT_W-1:0] r_cnt;
    logic             w_tick;

    assign w_tick = (r_cnt == CNT_LAST);
    assign o_tick = w_tick;

    always_ff @(posedge clk) begin
        if (reset || i_clear || !i_en || w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter. A 0->1 edge on i_tx_req while idle captures i_tx_data and sends
// start bit, 8 data bits LSB first and a stop bit, each CLK_PER_BIT cycles long.
//   clk        : system clock
//   reset      : synchronous, active-high reset
//   i_tx_req   : request level; a rising edge requests one frame
//   i_tx_data  : byte to send, sampled when the request is accepted
//   o_tx_busy  : high while a frame is in progress
//   o_uart_txd : serial line, idle high
module uart_tx
    import lib_uart::*;
#(
    parameter int unsigned CLK_PER_BIT = UART_CLK_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_tx_req,
    input  logic [7:0] i_tx_data,
    output logic       o_tx_busy,
    output logic       o_uart_txd
);

    UART_TX_STATE r_state;
    logic         r_req;
    logic [7:0]   r_shift;
    logic [2:0]   r_bit_cnt;
    logic         r_busy;
    logic         r_txd;
    logic         w_start;
    logic         w_tick;

    // Edges arriving outside IDLE are dropped; r_req still tracks them so they never fire later.
    assign w_start = i_tx_req && !r_req && (r_state == IDLE);

    uart_baud_cnt #(
        .CLK_PER_BIT (CLK_PER_BIT)
    ) u_baud_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_start),
        .i_en    (r_state != IDLE),
        .o_tick  (w_tick)
    );

    // r_txd follows the phase one cycle later, so the line falls the cycle after accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_req     <= 1'b1;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_busy    <= 1'b0;
            r_txd     <= 1'b1;
        end else begin
            r_req <= i_tx_req;
            case (r_state)
                IDLE: begin
                    r_txd <= 1'b1;
                    if (w_start) begin
                        r_shift <= i_tx_data;
                        r_busy  <= 1'b1;
                        r_state <= START;
                    end
                end
                START: begin
                    r_txd <= 1'b0;
                    if (w_tick) begin
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    r_txd <= r_shift[0];
                    if (w_tick) begin
                        r_shift <= r_shift >> 1;
                        if (r_bit_cnt == 3'd7) begin
                            r_bit_cnt <= '0;
                            r_state   <= STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                end
                STOP: begin
                    r_txd <= 1'b1;
                    if (w_tick) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_txd   <= 1'b1;
                end
            endcase
        end
    end

    assign o_tx_busy  = r_busy;
    assign o_uart_txd = r_txd;

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

    localparam int unsigned CPB = 4;
    localparam int unsigned FRAME_CYC = 10 * CPB;

    logic       clk;
    logic       reset;
    logic       i_tx_req;
    logic [7:0] i_tx_data;
    logic       o_tx_busy;
    logic       o_uart_txd;

    int n_checks = 0;
    int n_errors = 0;

    uart_tx #(
        .CLK_PER_BIT (CPB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_tx_req   (i_tx_req),
        .i_tx_data  (i_tx_data),
        .o_tx_busy  (o_tx_busy),
        .o_uart_txd (o_uart_txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Line and busy must both read idle for n cycles.
    task automatic idle_check(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            chk($sformatf("%s_txd[%0d]", tag, i), o_uart_txd, 1'b1);
            chk($sformatf("%s_busy[%0d]", tag, i), o_tx_busy, 1'b0);
        end
    endtask

    // Request one frame for d and check every cycle of it against the ideal 8N1 waveform.
    // glitch>0 re-pulses tx_req (0 at glitch-1, 1 at glitch) mid-frame with data 8'h12.
    // Unless hold_req, tx_req drops before the final frame edge so a new edge may follow.
    task automatic run_frame(input logic [7:0] d, input int glitch, input bit hold_req);
        logic [9:0] frame;
        logic       exp_txd;
        frame = {1'b1, d, 1'b0};
        i_tx_req  = 1'b1;
        i_tx_data = d;
        step();
        chk($sformatf("accept_busy_%h", d), o_tx_busy, 1'b1);
        chk($sformatf("accept_txd_%h", d), o_uart_txd, 1'b1);
        for (int k = 1; k <= int'(FRAME_CYC); k++) begin
            i_tx_data = 8'($urandom);
            if (glitch > 0 && k == glitch - 1) i_tx_req = 1'b0;
            if (glitch > 0 && k == glitch) begin
                i_tx_req  = 1'b1;
                i_tx_data = 8'h12;
            end
            if (!hold_req && k == int'(FRAME_CYC)) i_tx_req = 1'b0;
            step();
            exp_txd = frame[(k - 1) / int'(CPB)];
            chk($sformatf("txd_%h[%0d]", d, k), o_uart_txd, exp_txd);
            chk($sformatf("busy_%h[%0d]", d, k), o_tx_busy, k < int'(FRAME_CYC));
        end
    endtask

    initial begin
        logic [7:0] rnd;
        int         gap;

        // Reset with tx_req held high: no frame may fire on release.
        reset     = 1'b1;
        i_tx_req  = 1'b1;
        i_tx_data = 8'h00;
        step();
        step();
        chk("reset_txd", o_uart_txd, 1'b1);
        chk("reset_busy", o_tx_busy, 1'b0);
        reset = 1'b0;
        idle_check("held_through_reset", 10);
        i_tx_req = 1'b0;
        idle_check("idle", 20);

        // Basic frame.
        run_frame(8'hA5, 0, 1'b0);
        idle_check("after_a5", 5);

        // Request held high after the frame: exactly one frame.
        run_frame(8'h3C, 0, 1'b1);
        idle_check("hold_3c", 50);
        i_tx_req = 1'b0;
        step();

        // Back-to-back: second edge in the first idle cycle.
        run_frame(8'h00, 0, 1'b0);
        run_frame(8'hFF, 0, 1'b0);
        idle_check("after_ff", 5);

        // Mid-frame re-request is dropped.
        run_frame(8'h55, 15, 1'b0);
        idle_check("after_55", 20);

        // Reset at cycle 18 of a frame.
        i_tx_req  = 1'b1;
        i_tx_data = 8'hC3;
        step();
        for (int k = 1; k < 18; k++) step();
        chk("pre_reset_busy_c3", o_tx_busy, 1'b1);
        reset = 1'b1;
        step();
        chk("midreset_txd", o_uart_txd, 1'b1);
        chk("midreset_busy", o_tx_busy, 1'b0);
        reset    = 1'b0;
        i_tx_req = 1'b0;
        idle_check("after_midreset", 20);
        run_frame(8'hC3, 0, 1'b0);
        idle_check("after_c3", 3);

        // Reset and request edge in the same cycle: reset wins, held request stays silent.
        reset    = 1'b1;
        i_tx_req = 1'b1;
        step();
        reset = 1'b0;
        idle_check("reset_vs_req", 12);
        i_tx_req = 1'b0;
        step();

        // Random bytes with random idle gaps (gap 0 is back-to-back).
        for (int f = 0; f < 6; f++) begin
            rnd = 8'($urandom);
            gap = int'($urandom_range(0, 3));
            run_frame(rnd, 0, 1'b0);
            if (gap > 0) idle_check($sformatf("rnd_gap%0d", f), gap);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
